serdes_deserializer: RTL and testbench
======================================

Name: serdes_deserializer

Overview:
- Receive end of the PLL-SERDES link: consumes the recovered serial bit stream, one bit per `bit_valid` strobe, timed by the PLL/DCO-derived sample clock domain.
- Hunts for a sync word, verifies frame alignment, then emits parallel payload words with a valid pulse.
- Declares loss of sync after repeated sync-slot misses and returns to hunting.
- Mirror of the serializer fed by the PLL output clock.

Parameters:
- WIDTH, 8, bits per word; first received bit becomes the MSB.
- SYNC_WORD, 8'hBC, sync pattern occupying frame slot 0.
- PAYLOAD_WORDS, 4, payload words per frame after the sync word (frame = 1 + PAYLOAD_WORDS words).
- LOCK_COUNT, 2, consecutive correct syncs (including the hunt hit) required to reach LOCKED; minimum 1.
- MISS_LIMIT, 3, consecutive sync-slot mismatches in LOCKED that force HUNT; minimum 1.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- sdata, input, 1, serial data bit.
- bit_valid, input, 1, qualifies sdata for one clk cycle; no state changes when low.
- data_out, output, WIDTH, last payload word.
- data_valid, output, 1, one-cycle pulse when data_out updates.
- frame_start, output, 1, asserted with data_valid on payload word 1 of a frame.
- locked, output, 1, high while in LOCKED.
- sync_err, output, 1, one-cycle pulse on a sync-slot mismatch while in LOCKED.
- state, output, 2, current state: 0 HUNT, 1 VERIFY, 2 LOCKED.

Behaviour:
- Reset (async, rst=1) clears all registers:
  - data_out=0; data_valid, frame_start, locked, sync_err = 0; state = HUNT.
  - shift register, bit_cnt, word_idx, good_cnt and miss_cnt = 0.
- Bit intake: on each cycle with bit_valid=1, cand = {shreg[WIDTH-2:0], sdata} and shreg <= cand. Nothing else happens when bit_valid=0.
- Word completion (VERIFY/LOCKED only): occurs on the bit_valid cycle where bit_cnt == WIDTH-1. The word is cand. On that cycle bit_cnt -> 0 and word_idx -> (word_idx + 1) mod (PAYLOAD_WORDS + 1). Otherwise bit_cnt increments.
- HUNT:
  - Each bit_valid compares cand against SYNC_WORD (sliding, bit-granular).
  - On a match: bit_cnt=0, word_idx=1.
  - If LOCK_COUNT == 1, go to LOCKED. Otherwise go to VERIFY with good_cnt=1.
- VERIFY:
  - Payload words are counted but not output.
  - Sync-slot word (word_idx == 0 at completion) equal to SYNC_WORD: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED with miss_cnt=0.
  - Sync-slot mismatch: go to HUNT immediately, good_cnt=0, shreg retained.
- LOCKED:
  - Payload word completion: data_out <= word, data_valid=1 the following cycle (1-cycle latency from the completing bit_valid). frame_start=1 if that word is slot 1.
  - Sync-slot match: miss_cnt=0.
  - Sync-slot mismatch: sync_err pulse and miss_cnt++. If miss_cnt reaches MISS_LIMIT, go to HUNT with locked=0 the next cycle. Otherwise stay locked and keep emitting payload (flywheel).
- Sync words are never presented on data_out.
- `locked` is registered and equals (state == LOCKED).
- Counter widths: $clog2 of their respective limits; no wrap beyond limit (saturating compare).
- Reset mid-frame: immediate return to HUNT; a partially assembled word is discarded.
- bit_valid back-to-back every cycle is supported; gaps of any length between bits are allowed.

Decomposition:
- Shared include `serdes_defs.vh`: state encodings ST_HUNT/ST_VERIFY/ST_LOCKED and default SYNC_WORD. The serializer uses the same sync constant.
- One natural sub-module, `deser_shift_reg`: WIDTH-bit MSB-first shift register with cand output and a combinational sync-match flag. The FSM, counters and output registers stay in the top.

Test Plan:
- Clean lock: reset, then send 3 bits of 0 followed by frames BC,11,22,33,44 repeated with bit_valid every 4 clks -> state HUNT->VERIFY->LOCKED after the 2nd BC. Next frame gives data_valid pulses with 11(frame_start=1),22,33,44. No BC appears on data_out.
- Bit slip in hunt: stream 5'b10111 prefix before frames -> sync found at correct bit offset, same output words as the clean-lock case.
- Verify failure: BC, 4 payload, then A5 in the sync slot -> VERIFY->HUNT, locked never asserts, no data_valid.
- Flywheel and loss: once locked, corrupt 2 consecutive sync slots -> 2 sync_err pulses, payload still output, locked stays 1. Corrupt 3 consecutive -> locked=0 after the 3rd, state HUNT, relock after 2 good syncs.
- Gaps: bit_valid held low 50 clks mid-word -> no state change; the word completes correctly when bits resume.
- Async reset mid-frame while locked: assert rst between clk edges -> all outputs 0 and state HUNT immediately. After release, relock requires a fresh HUNT->VERIFY sequence.

Source files
------------

// File: rtl/serdes_deserializer_pkg.sv
// Shared definitions for the SERDES receive path: state encodings,
// the default sync pattern (common with the serializer) and a counter
// width helper.
package serdes_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hBC;

  // Bits needed to hold values 0..limit; never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// MSB-first serial-to-parallel shift register. Presents the candidate
// word (stored history plus the incoming bit) and a combinational flag
// that is high when that candidate equals the sync pattern.
module deser_shift_reg
  import serdes_deserializer_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC_WORD_DEFAULT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_valid_i,
  input  logic             sdata_i,
  output logic [WIDTH-1:0] cand_o,
  output logic             sync_hit_o
);

  // Only WIDTH-1 bits of history are needed; the newest bit comes from sdata_i.
  logic [WIDTH-2:0] shreg_q;

  assign cand_o     = {shreg_q, sdata_i};
  assign sync_hit_o = (cand_o == SYNC_WORD);

  // Shift in one bit per qualified strobe; hold otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else if (bit_valid_i) begin
      shreg_q <= cand_o[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/serdes_deserializer.sv
// Receive end of the SERDES link: hunts for the sync word bit by bit,
// verifies alignment over several frames, then emits payload words.
// Repeated sync-slot misses while locked drop the link back to hunting.
module serdes_deserializer
  import serdes_deserializer_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD     = WIDTH'(SYNC_WORD_DEFAULT),
  parameter int               PAYLOAD_WORDS = 4,
  parameter int               LOCK_COUNT    = 2,
  parameter int               MISS_LIMIT    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdata,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_start,
  output logic             locked,
  output logic             sync_err,
  output logic [1:0]       state
);

  localparam int BC_W  = cnt_w(WIDTH - 1);
  localparam int IDX_W = cnt_w(PAYLOAD_WORDS);
  localparam int GC_W  = cnt_w(LOCK_COUNT);
  localparam int MC_W  = cnt_w(MISS_LIMIT);

  localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_WORDS);
  localparam logic [GC_W-1:0]  GOOD_LAST = GC_W'(LOCK_COUNT - 1);
  localparam logic [MC_W-1:0]  MISS_LAST = MC_W'(MISS_LIMIT - 1);

  logic [WIDTH-1:0] cand;
  logic             sync_hit;

  state_e           state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
  logic [MC_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;

  logic             word_done;
  logic [IDX_W-1:0] idx_next;

  deser_shift_reg #(
    .WIDTH     (WIDTH),
    .SYNC_WORD (SYNC_WORD)
  ) u_shift (
    .clk_i       (clk),
    .rst_i       (rst),
    .bit_valid_i (bit_valid),
    .sdata_i     (sdata),
    .cand_o      (cand),
    .sync_hit_o  (sync_hit)
  );

  assign word_done = (bit_cnt_q == BIT_LAST);
  assign idx_next  = (word_idx_q >= IDX_LAST) ? '0 : word_idx_q + IDX_W'(1);

  // Next-state, counter and output decode; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    good_cnt_d    = good_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (sync_hit) begin
            bit_cnt_d  = '0;
            word_idx_d = IDX_W'(1);
            if (LOCK_COUNT == 1) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end else begin
              state_d    = ST_VERIFY;
              good_cnt_d = GC_W'(1);
            end
          end
        end

        ST_VERIFY: begin
          if (word_done) begin
            bit_cnt_d  = '0;
            word_idx_d = idx_next;
            if (word_idx_q == '0) begin
              if (sync_hit) begin
                if (good_cnt_q >= GOOD_LAST) begin
                  state_d    = ST_LOCKED;
                  miss_cnt_d = '0;
                  good_cnt_d = '0;
                end else begin
                  good_cnt_d = good_cnt_q + GC_W'(1);
                end
              end else begin
                // Misaligned: keep the shift history so hunting resumes sliding.
                state_d    = ST_HUNT;
                good_cnt_d = '0;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end

        ST_LOCKED: begin
          if (word_done) begin
            bit_cnt_d  = '0;
            word_idx_d = idx_next;
            if (word_idx_q != '0) begin
              data_out_d    = cand;
              data_valid_d  = 1'b1;
              frame_start_d = (word_idx_q == IDX_W'(1));
            end else if (sync_hit) begin
              miss_cnt_d = '0;
            end else begin
              // Flywheel through isolated misses; give up after MISS_LIMIT in a row.
              sync_err_d = 1'b1;
              if (miss_cnt_q >= MISS_LAST) begin
                state_d    = ST_HUNT;
                miss_cnt_d = '0;
              end else begin
                miss_cnt_d = miss_cnt_q + MC_W'(1);
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State, counters and registered outputs; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      good_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_serdes_deserializer.sv
// Directed bench for serdes_deserializer: payload words expected on
// data_out are queued as frames are sent and checked when they emerge.
`timescale 1ns/1ps
module tb_serdes_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sdata = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_start;
  logic       locked;
  logic       sync_err;
  logic [1:0] state;

  typedef struct packed {
    logic [7:0] data;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   err_seen = 0;

  serdes_deserializer dut (
    .clk         (clk),
    .rst         (rst),
    .sdata       (sdata),
    .bit_valid   (bit_valid),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every data_valid pulse must match the head of the queue.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sync_err === 1'b1) err_seen++;
      if (data_valid !== 1'b0) begin
        check("unexpected_data_valid", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("data_out", 32'(data_out), 32'(e.data));
          check("frame_start", 32'(frame_start), 32'(e.fs));
        end
      end
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sdata     = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input bit out, input bit fs);
    if (out) exp_q.push_back({w, fs});
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_payload(input bit out);
    send_word(8'h11, out, 1'b1);
    send_word(8'h22, out, 1'b0);
    send_word(8'h33, out, 1'b0);
    send_word(8'h44, out, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] sync_w, input bit out);
    send_word(sync_w, 1'b0, 1'b0);
    send_payload(out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Hunt hit, one verify frame, then lock with payload of that frame emitted.
  task automatic acquire(input string tag);
    send_word(8'hBC, 1'b0, 1'b0);
    check({tag, "_verify_state"}, 32'(state), 32'd1);
    check({tag, "_verify_unlocked"}, 32'(locked), 32'd0);
    send_payload(1'b0);
    send_word(8'hBC, 1'b0, 1'b0);
    check({tag, "_locked_state"}, 32'(state), 32'd2);
    check({tag, "_locked"}, 32'(locked), 32'd1);
    send_payload(1'b1);
  endtask

  initial begin
    fork
      monitor();
      begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
    join_none

    // Reset state
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_outputs", 32'({data_valid, frame_start, locked, sync_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean lock with a 3-bit zero prefix
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    check("clean_hunt", 32'(state), 32'd0);
    acquire("clean");
    send_frame(8'hBC, 1'b1);
    check("clean_queue_empty", 32'(exp_q.size()), 32'd0);
    check("clean_no_err", 32'(err_seen), 32'd0);

    // Verify failure: bad sync slot in VERIFY drops back to HUNT
    do_reset();
    send_word(8'hBC, 1'b0, 1'b0);
    check("vfail_verify", 32'(state), 32'd1);
    send_payload(1'b0);
    send_word(8'hA5, 1'b0, 1'b0);
    check("vfail_hunt", 32'(state), 32'd0);
    check("vfail_unlocked", 32'(locked), 32'd0);
    check("vfail_no_err", 32'(err_seen), 32'd0);

    // Bit slip: 5-bit prefix before the first sync word
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("slip_hunt", 32'(state), 32'd0);
    acquire("slip");

    // Flywheel: two bad syncs tolerated, payload keeps flowing
    send_frame(8'hA5, 1'b1);
    send_frame(8'h5A, 1'b1);
    check("fly_err_count", 32'(err_seen), 32'd2);
    check("fly_locked", 32'(locked), 32'd1);
    check("fly_state", 32'(state), 32'd2);
    send_frame(8'hBC, 1'b1);

    // Loss: three consecutive bad syncs force HUNT
    send_frame(8'hA5, 1'b1);
    send_frame(8'h00, 1'b1);
    check("loss_still_locked", 32'(locked), 32'd1);
    send_word(8'h5A, 1'b0, 1'b0);
    check("loss_unlocked", 32'(locked), 32'd0);
    check("loss_state", 32'(state), 32'd0);
    check("loss_err_count", 32'(err_seen), 32'd5);
    send_payload(1'b0);
    acquire("relock");

    // Gap of 50 clocks mid-word
    send_word(8'hBC, 1'b0, 1'b0);
    send_word(8'h11, 1'b1, 1'b1);
    exp_q.push_back({8'h22, 1'b0});
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (50) @(negedge clk);
    check("gap_state", 32'(state), 32'd2);
    check("gap_pending", 32'(exp_q.size()), 32'd1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_word(8'h33, 1'b1, 1'b0);
    send_word(8'h44, 1'b1, 1'b0);
    check("gap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Async reset mid-frame while locked
    send_word(8'hBC, 1'b0, 1'b0);
    send_word(8'h11, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    check("pre_rst_data_out", 32'(data_out), 32'h11);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_outputs", 32'({data_valid, frame_start, locked, sync_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    acquire("post_rst");
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
